ncl_sync_operand_src: RTL and testbench

- Clocked source stage that injects operands into the dual-rail NCL ripple-adder chain.
- Accepts synchronous A/B/carry-in words over a valid/ready handshake.
- Drives each word into the chain as a four-phase DATA/NULL wavefront, paced by the chain's completion (COMP) outputs.
- Registered outputs, 2-flop synchronisers on all COMP inputs, watchdog on stalled wavefronts.

---
 rtl/ncl_sync_operand_src_if.sv | 24 ++
 rtl/ncl_sync_operand_src.sv | 101 ++++++++++
 tb/tb_ncl_sync_operand_src.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncl_sync_operand_src_if.sv
// ncl_sync_operand_src_if: operand handshake, dual-rail drive and completion feedback bundle
interface ncl_sync_operand_src_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_cin;
    logic [2*WIDTH-1:0] A;
    logic [2*WIDTH-1:0] B;
    logic [1:0]         carryin;
    logic [WIDTH-1:0]   ACOMP;
    logic [WIDTH-1:0]   BCOMP;
    logic               carryinCOMP;
    modport master (
        output in_valid, in_a, in_b, in_cin, ACOMP, BCOMP, carryinCOMP,
        input  in_ready, A, B, carryin
    );
    modport slave (
        input  in_valid, in_a, in_b, in_cin, ACOMP, BCOMP, carryinCOMP,
        output in_ready, A, B, carryin
    );
endinterface

// File: rtl/ncl_sync_operand_src.sv
// ncl_sync_operand_src: clocked source injecting operand words as DATA/NULL wavefronts into an NCL adder chain
module ncl_sync_operand_src #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  init,
    ncl_sync_operand_src_if.slave io,
    output logic                  busy,
    output logic                  stall,
    output logic                  proto_err,
    output logic [15:0]           word_cnt
);
    localparam int CW  = 2 * WIDTH + 1;
    localparam int WDW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, DATA, NUL} state_t;

    state_t                         r_state, w_next;
    logic [SYNC_STAGES-1:0][CW-1:0] r_sync;
    logic [CW-1:0]                  w_comp;
    logic                           w_all_hi, w_all_lo, w_accept, w_pe_now, r_pe_prev;
    logic [WDW-1:0]                 r_wd, w_wd_next;
    logic [2*WIDTH-1:0]             r_a, r_b, w_enc_a, w_enc_b;
    logic [1:0]                     r_cin;

    // value 1 drives rail pattern 01, value 0 drives 10
    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        assign w_enc_a[2*i +: 2] = {~io.in_a[i], io.in_a[i]};
        assign w_enc_b[2*i +: 2] = {~io.in_b[i], io.in_b[i]};
    end

    assign w_comp      = r_sync[SYNC_STAGES-1];
    assign w_all_hi    = &w_comp;
    assign w_all_lo    = ~|w_comp;
    assign io.in_ready = ~init & (r_state == IDLE) & w_all_lo;
    assign w_accept    = io.in_valid & io.in_ready;
    assign busy        = r_state != IDLE;
    assign w_pe_now    = (r_state == IDLE) & ~w_all_lo;
    assign io.A        = r_a;
    assign io.B        = r_b;
    assign io.carryin  = r_cin;

    // completion inputs are asynchronous to clk: shift through a flop chain
    always_ff @(posedge clk or posedge init) begin
        if (init) r_sync <= '0;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], {io.carryinCOMP, io.BCOMP, io.ACOMP}};
    end

    // next wavefront phase and watchdog count (cleared on any phase change)
    always_comb begin
        w_next    = r_state;
        w_wd_next = '0;
        if (r_state == IDLE && w_accept)     w_next = DATA;
        else if (r_state == DATA && w_all_hi) w_next = NUL;
        else if (r_state == NUL && w_all_lo)  w_next = IDLE;
        if (w_next == r_state && busy)
            w_wd_next = (r_wd == WDW'(TIMEOUT)) ? r_wd : r_wd + WDW'(1);
    end

    // phase register
    always_ff @(posedge clk or posedge init) begin
        if (init) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // dual-rail output flops: load DATA on accept, return to NULL once the chain reports all-high
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= '0;
        end else if (w_accept) begin
            r_a   <= w_enc_a;
            r_b   <= w_enc_b;
            r_cin <= {~io.in_cin, io.in_cin};
        end else if (r_state == DATA && w_all_hi) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= '0;
        end
    end

    // watchdog, protocol-error flag and completed-word counter
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_wd      <= '0;
            r_pe_prev <= 1'b0;
            stall     <= 1'b0;
            proto_err <= 1'b0;
            word_cnt  <= '0;
        end else begin
            r_wd      <= w_wd_next;
            r_pe_prev <= w_pe_now;
            if (TIMEOUT > 0 && busy && w_wd_next == WDW'(TIMEOUT)) stall <= 1'b1;
            if (w_pe_now && r_pe_prev) proto_err <= 1'b1;
            if (r_state == NUL && w_all_lo) word_cnt <= word_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_ncl_sync_operand_src.sv
// tb_ncl_sync_operand_src: scoreboard bench for the NCL operand source
module tb_ncl_sync_operand_src;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int TO = 20;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        busy, stall, proto_err;
    logic [15:0] word_cnt;
    logic [2*W:0] comp_man = '0;
    logic [2*W:0] comp_echo = '0;
    logic        echo_en = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [17:0] sb[$];
    logic [7:0]  pa = '0, pb = '0;
    logic [1:0]  pc = '0;

    // hand-encoded: value 1 -> 01, value 0 -> 10, MSB pair first
    vec_t vecs[8] = '{
        {4'h0, 4'hF, 1'b0, 8'hAA, 8'h55, 2'b10},
        {4'hF, 4'h0, 1'b1, 8'h55, 8'hAA, 2'b01},
        {4'h9, 4'h6, 1'b1, 8'h69, 8'h96, 2'b01},
        {4'h5, 4'hA, 1'b0, 8'h99, 8'h66, 2'b10},
        {4'h3, 4'hC, 1'b1, 8'hA5, 8'h5A, 2'b01},
        {4'h1, 4'h8, 1'b0, 8'hA9, 8'h6A, 2'b10},
        {4'h7, 4'hE, 1'b1, 8'h95, 8'h56, 2'b01},
        {4'h6, 4'h9, 1'b0, 8'h96, 8'h69, 2'b10}
    };

    ncl_sync_operand_src_if #(.WIDTH(W)) ifc ();

    ncl_sync_operand_src #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .init(init), .io(ifc),
        .busy(busy), .stall(stall), .proto_err(proto_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    assign {ifc.carryinCOMP, ifc.BCOMP, ifc.ACOMP} = echo_en ? comp_echo : comp_man;

    // chain model: each rail pair's completion follows its DATA/NULL state one cycle later
    always @(negedge clk) begin
        for (int i = 0; i < W; i++) begin
            comp_echo[i]     = |ifc.A[2*i +: 2];
            comp_echo[W + i] = |ifc.B[2*i +: 2];
        end
        comp_echo[2*W] = |ifc.carryin;
    end

    // monitor: rail legality every cycle; each new DATA wavefront is popped and compared
    always @(negedge clk) begin
        logic ok;
        logic [17:0] e;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (ifc.A[2*i +: 2] == 2'b11 || ifc.B[2*i +: 2] == 2'b11) ok = 1'b0;
            if (pa[2*i +: 2] != 0 && ifc.A[2*i +: 2] != 0 && pa[2*i +: 2] != ifc.A[2*i +: 2]) ok = 1'b0;
            if (pb[2*i +: 2] != 0 && ifc.B[2*i +: 2] != 0 && pb[2*i +: 2] != ifc.B[2*i +: 2]) ok = 1'b0;
        end
        if (ifc.carryin == 2'b11 || (pc != 0 && ifc.carryin != 0 && pc != ifc.carryin)) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rails: A=%h B=%h cin=%b after A=%h B=%h cin=%b, need no 11 and no direct 10<->01",
                     ifc.A, ifc.B, ifc.carryin, pa, pb, pc);
        end
        if (pa == 0 && pb == 0 && pc == 0 && (ifc.A != 0 || ifc.B != 0 || ifc.carryin != 0)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wave: unexpected DATA A=%h B=%h cin=%b", ifc.A, ifc.B, ifc.carryin);
            end else begin
                e = sb.pop_front();
                if ({ifc.A, ifc.B, ifc.carryin} !== e) begin
                    failures++;
                    $display("FAIL wave: got A=%h B=%h cin=%b expected A=%h B=%h cin=%b",
                             ifc.A, ifc.B, ifc.carryin, e[17:10], e[9:2], e[1:0]);
                end
            end
        end
        pa = ifc.A;
        pb = ifc.B;
        pc = ifc.carryin;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // present a word at a falling edge and hold valid until the rising edge that accepts it
    task automatic send(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        ifc.in_a     = v.a;
        ifc.in_b     = v.b;
        ifc.in_cin   = v.c;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept: in_ready=0 after %0d cycles, expected 1", n);
        end else begin
            sb.push_back({v.ea, v.eb, v.ec});
            @(posedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        while (!ifc.in_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, ifc.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stable;
        ifc.in_valid = 1'b0;
        ifc.in_a = '0;
        ifc.in_b = '0;
        ifc.in_cin = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_A", ifc.A, 0);
        chk("rst_B", ifc.B, 0);
        chk("rst_cin", ifc.carryin, 0);
        chk("rst_ready", ifc.in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_cnt", word_cnt, 0);
        init = 1'b0;
        #1;
        wait_ready("rst_release_ready", SS + 1);

        // single word 9/6/1 with hand-timed completion
        send(vecs[2]);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        comp_man = '1;
        repeat (2) @(negedge clk);
        chk("single_hold_data", ifc.A, 8'h69);
        @(negedge clk);
        chk("single_null_A", ifc.A, 0);
        chk("single_null_cin", ifc.carryin, 0);
        comp_man = '0;
        repeat (2) @(negedge clk);
        chk("single_cnt_before", word_cnt, 0);
        @(negedge clk);
        chk("single_cnt", word_cnt, 1);
        chk("single_ready", ifc.in_ready, 1);

        // back-to-back with echoing chain, valid held high
        echo_en = 1'b1;
        for (int k = 0; k < 8; k++) send(vecs[k]);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_idle("b2b_idle");
        chk("b2b_cnt", word_cnt, 9);
        @(negedge clk);
        echo_en = 1'b0;

        // partial completion: BCOMP[2] withheld
        send(vecs[3]);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        comp_man = 9'h1BF;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (ifc.A != 8'h99 || ifc.B != 8'h66 || ifc.carryin != 2'b10 || !busy) stable = 1'b0;
        end
        chk("partial_hold", stable, 1);
        comp_man = '1;
        repeat (2) @(negedge clk);
        chk("partial_still_data", ifc.B, 8'h66);
        @(negedge clk);
        chk("partial_null", ifc.B, 0);
        comp_man = '0;
        wait_idle("partial_idle");
        chk("partial_cnt", word_cnt, 10);
        chk("partial_stall", stall, 1);

        // init asserted mid-DATA
        send(vecs[3]);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_data_A", ifc.A, 8'h99);
        init = 1'b1;
        #1;
        chk("init_A", ifc.A, 0);
        chk("init_B", ifc.B, 0);
        chk("init_cin", ifc.carryin, 0);
        chk("init_busy", busy, 0);
        chk("init_stall", stall, 0);
        chk("init_cnt", word_cnt, 0);
        @(negedge clk);
        chk("init_ready", ifc.in_ready, 0);
        init = 1'b0;
        #1;
        wait_ready("init_release_ready", SS + 1);

        // watchdog with completion never arriving
        send(vecs[4]);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("wd_before", stall, 0);
        @(negedge clk);
        chk("wd_set", stall, 1);
        chk("wd_data_A", ifc.A, 8'hA5);
        repeat (5) @(negedge clk);
        chk("wd_sticky", stall, 1);
        chk("wd_busy", busy, 1);
        init = 1'b1;
        #1;
        chk("wd_cleared", stall, 0);
        @(negedge clk);
        init = 1'b0;
        #1;
        wait_ready("wd_release_ready", SS + 1);

        // input changes with valid low are ignored
        ifc.in_a = 4'hF;
        ifc.in_b = 4'h3;
        repeat (5) @(negedge clk);
        chk("ignore_busy", busy, 0);
        chk("ignore_A", ifc.A, 0);

        // protocol error: ACOMP[0] high while idle
        chk("pe_clear", proto_err, 0);
        comp_man = 9'h001;
        repeat (3) @(negedge clk);
        chk("pe_ready_low", ifc.in_ready, 0);
        comp_man = '0;
        repeat (4) @(negedge clk);
        chk("pe_set", proto_err, 1);
        chk("pe_ready_back", ifc.in_ready, 1);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
